// File: rtl/fir_sym_mac.sv
// Symmetric-coefficient FIR filter with one time-shared multiplier.
// Each accepted sample walks the H folded tap pairs one per cycle. The
// result is then rounded, saturated and strobed out on out_valid.
module fir_sym_mac #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned TAPS  = 8,
  parameter int unsigned SHIFT = 11,
  parameter int unsigned OW    = 16
) (
  input  logic                           clk,
  input  logic                           rest,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DW-1:0]           in_data,
  input  logic                           coef_we,
  input  logic [$clog2(TAPS/2)-1:0]      coef_addr,
  input  logic signed [CW-1:0]           coef_data,
  output logic                           out_valid,
  output logic signed [OW-1:0]           out_data,
  output logic                           out_sat
);

  localparam int unsigned H  = TAPS / 2;
  localparam int unsigned KW = $clog2(H);
  localparam int unsigned TW = $clog2(TAPS);
  localparam int unsigned PW = DW + 1 + CW;
  localparam int unsigned AW = PW + KW;
  localparam int unsigned RW = AW + 1;

  // Rounding offset and output clip limits, all at rounding width
  localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] SMAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [RW-1:0] SMIN = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                state, state_d;
  logic signed [DW-1:0]  x [TAPS];
  logic signed [CW-1:0]  c [H];
  logic [KW-1:0]         k, k_d;
  logic signed [AW-1:0]  acc, acc_d;
  logic                  in_ready_d;
  logic                  out_valid_d;
  logic signed [OW-1:0]  out_data_d;
  logic                  out_sat_d;

  logic                  accept;
  logic                  coef_wr;
  logic [TW-1:0]         km;
  logic signed [DW:0]    pre;
  logic signed [PW-1:0]  prod;
  logic signed [RW-1:0]  rnd;
  logic signed [RW-1:0]  r;

  assign accept  = in_valid && in_ready;
  assign coef_wr = coef_we && in_ready && ({1'b0, coef_addr} < (KW+1)'(H));

  // Folded pair k: pre-add mirrored taps, then one multiply
  assign km   = TW'(TAPS - 1) - TW'(k);
  assign pre  = (DW+1)'(x[TW'(k)]) + (DW+1)'(x[km]);
  assign prod = PW'(pre) * PW'(c[k]);

  // Round half toward +inf, then arithmetic scale-down
  assign rnd = RW'(acc) + HALF;
  assign r   = rnd >>> SHIFT;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    k_d         = k;
    acc_d       = acc;
    out_valid_d = 1'b0;
    out_data_d  = out_data;
    out_sat_d   = out_sat;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = MAC;
          acc_d   = '0;
          k_d     = '0;
        end
      end
      MAC: begin
        acc_d = acc + AW'(prod);
        k_d   = k + KW'(1);
        if (k == KW'(H - 1)) begin
          state_d = OUT;
        end
      end
      OUT: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        if (r > SMAX) begin
          out_data_d = OW'(SMAX);
          out_sat_d  = 1'b1;
        end else if (r < SMIN) begin
          out_data_d = OW'(SMIN);
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = OW'(r);
          out_sat_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // Control state, accumulator and registered outputs
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      state     <= state_d;
      k         <= k_d;
      acc       <= acc_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_sat   <= out_sat_d;
    end
  end

  // Sample delay line, shifts only on an accepted sample
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        x[i] <= '0;
      end
    end else if (accept) begin
      x[0] <= in_data;
      for (int i = 1; i < int'(TAPS); i++) begin
        x[i] <= x[i-1];
      end
    end
  end

  // Coefficient bank, writable only while idle and ready
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      for (int i = 0; i < int'(H); i++) begin
        c[i] <= '0;
      end
    end else if (coef_wr) begin
      c[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_fir_sym_mac.sv
// Directed bench for fir_sym_mac: vector table plus handshake/reset sequences.
module tb_fir_sym_mac;

  localparam int DW = 16, CW = 16, TAPS = 8, SHIFT = 11, OW = 16;

  logic                 clk = 1'b0;
  logic                 rest = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 coef_we = 1'b0;
  logic [1:0]           coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic                 out_valid;
  logic signed [OW-1:0] out_data;
  logic                 out_sat;

  int n_cmp = 0;
  int n_bad = 0;

  fir_sym_mac #(.DW(DW), .CW(CW), .TAPS(TAPS), .SHIFT(SHIFT), .OW(OW)) dut (
    .clk(clk), .rest(rest),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit ld;
    int c0, c1, c2, c3;
    int din;
    int exp;
    int sat;
    bit chk;
  } vec_t;

  vec_t tv[$];

  function automatic void add(bit r, bit l, int c0, int c1, int c2, int c3,
                              int din, int exp, int sat, bit chk);
    vec_t v;
    v.rst = r; v.ld = l; v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3;
    v.din = din; v.exp = exp; v.sat = sat; v.chk = chk;
    tv.push_back(v);
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) until in_ready is high
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rest = 1'b1;
    #1;
    chk("rst in_ready", int'(in_ready), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_data", int'(out_data), 0);
    chk("rst out_sat", int'(out_sat), 0);
    @(negedge clk);
    rest = 1'b0;
    #1;
    chk("rst release in_ready low", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("rst release in_ready high", int'(in_ready), 1);
  endtask

  task automatic write_coef(input int a, input int v);
    bit ok;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) chk("coef ready timeout", 0, 1);
    coef_we   = 1'b1;
    coef_addr = 2'(a);
    coef_data = 16'(v);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic load4(input int c0, input int c1, input int c2, input int c3);
    write_coef(0, c0);
    write_coef(1, c1);
    write_coef(2, c2);
    write_coef(3, c3);
  endtask

  // Offer one sample; optional coef write in the accept cycle and/or while busy
  task automatic send(input int din, input bit hold, input bit we, input int wa,
                      input int wd, input bit busy_we, output int got,
                      output int gsat, output int lat, output int lows);
    bit ok;
    got = 0; gsat = 0; lat = -1; lows = 0;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) begin
      chk("send ready timeout", 0, 1);
      return;
    end
    in_valid  = 1'b1;
    in_data   = 16'(din);
    coef_we   = we;
    coef_addr = 2'(wa);
    coef_data = 16'(wd);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    coef_we = busy_we;
    if (!in_ready) lows++;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat  = n;
        got  = int'(out_data);
        gsat = int'(out_sat);
        break;
      end
      if (!in_ready) lows++;
    end
    coef_we = 1'b0;
    if (lat < 0) chk("out_valid timeout", 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int got, gs, lat, lows, seen;
    int step_exp[8];

    // Impulse through c={5,60,257,476}
    add(1, 1, 5, 60, 257, 476, 2048, 5, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 60, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 257, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 476, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 476, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 257, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 60, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 5, 0, 1);
    // Step: running sums of the taps
    add(0, 0, 0, 0, 0, 0, 2048, 5, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2048, 65, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2048, 322, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2048, 798, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2048, 1274, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2048, 1531, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2048, 1591, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2048, 1596, 0, 1);
    // Rounding at the half-LSB boundary
    add(1, 1, 1, 0, 0, 0, 1024, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1023, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, -1025, -1, 0, 1);
    // Saturation both ways
    add(0, 1, 32767, 32767, 32767, 32767, 32767, 32767, 1, 1);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 0, 32767, 32767, 1, 1);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 0, -32768, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, -32768, -32768, 1, 1);

    do_reset();

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      if (tv[i].ld) load4(tv[i].c0, tv[i].c1, tv[i].c2, tv[i].c3);
      send(tv[i].din, 1'b0, 1'b0, 0, 0, 1'b0, got, gs, lat, lows);
      chk($sformatf("vec%0d latency", i), lat, 5);
      if (tv[i].chk) begin
        chk($sformatf("vec%0d out_data", i), got, tv[i].exp);
        chk($sformatf("vec%0d out_sat", i), gs, tv[i].sat);
      end
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d strobe width", i), int'(out_valid), 0);
      if (tv[i].chk) chk($sformatf("vec%0d out_data hold", i), int'(out_data), tv[i].exp);
    end

    // Step with in_valid held high: handshake alone paces the samples
    step_exp = '{5, 65, 322, 798, 1274, 1531, 1591, 1596};
    do_reset();
    load4(5, 60, 257, 476);
    for (int i = 0; i < 10; i++) begin
      send(2048, 1'b1, 1'b0, 0, 0, 1'b0, got, gs, lat, lows);
      chk($sformatf("hold%0d out_data", i), got, step_exp[(i < 7) ? i : 7]);
      chk($sformatf("hold%0d latency", i), lat, 5);
      chk($sformatf("hold%0d ready low cycles", i), lows, 5);
    end
    in_valid = 1'b0;

    // Reset during MAC: no strobe, everything zeroed
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'(2048);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rest = 1'b1;
    #1;
    chk("midmac rst out_valid", int'(out_valid), 0);
    chk("midmac rst out_data", int'(out_data), 0);
    chk("midmac rst in_ready", int'(in_ready), 0);
    @(negedge clk);
    rest = 1'b0;
    #1;
    chk("midmac release in_ready low", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("midmac release in_ready high", int'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("midmac no strobe", seen, 0);

    // Coefficients cleared by reset
    send(2048, 1'b0, 1'b0, 0, 0, 1'b0, got, gs, lat, lows);
    chk("post rst zero coef", got, 0);
    load4(5, 60, 257, 476);
    // Delay line cleared: only the one 2048 is present, at x[1]
    send(0, 1'b0, 1'b0, 0, 0, 1'b0, got, gs, lat, lows);
    chk("post rst delay line", got, 60);

    // Coefficient write while busy is dropped
    send(0, 1'b0, 1'b0, 2, 1000, 1'b1, got, gs, lat, lows);
    chk("busy write ignored", got, 257);

    // Write and accept in the same cycle: new coefficient is used
    send(0, 1'b0, 1'b1, 3, 100, 1'b0, got, gs, lat, lows);
    chk("same cycle write", got, 100);
    send(0, 1'b0, 1'b0, 0, 0, 1'b0, got, gs, lat, lows);
    chk("mirror tap new coef", got, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
